// File: rtl/dsi_tx_pkg.sv
// Shared definitions for the DSI TX line buffer: sideband bit positions
// inside a stored word and the framing FSM state encoding.
package dsi_tx_pkg;

  localparam int SB_BITS = 2;

  function automatic int sb_eop_pos(input int data_width);
    return data_width;
  endfunction

  function automatic int sb_sop_pos(input int data_width);
    return data_width + 1;
  endfunction

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_IN_LINE = 1'b1
  } frame_state_e;

endpackage

// File: rtl/dsi_tx_line_buffer_ram.sv
// Simple dual-port single-clock RAM with a registered read port.
// A read of the address being written in the same cycle returns the old contents.
module dsi_sc_ram #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dsi_tx_line_buffer.sv
// Pixel line buffer between the Avalon-ST pixel source and the DSI packet assembler.
// Optional high-water mark output max_level is enabled by DSI_TX_LINE_BUFFER_WATERMARK_EN.
module dsi_tx_line_buffer
  import dsi_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 1024,
  parameter int THRESHOLD_BYTES = 640,
  parameter int AFULL_MARGIN    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    avl_st_in_data,
  input  logic                     avl_st_in_valid,
  input  logic                     avl_st_in_startofpacket,
  input  logic                     avl_st_in_endofpacket,
  output logic                     avl_st_in_ready,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    fifo_data,
  output logic                     fifo_sop,
  output logic                     fifo_eop,
  output logic                     fifo_not_empty,
  output logic                     fifo_line_ready,
  input  logic                     fifo_read_ack,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [$clog2(DEPTH):0]   lines_held,
  output logic                     framing_err,
  output logic                     underflow_err
`ifdef DSI_TX_LINE_BUFFER_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int RW     = DATA_WIDTH + SB_BITS;
  localparam int SB_EOP = sb_eop_pos(DATA_WIDTH);
  localparam int SB_SOP = sb_sop_pos(DATA_WIDTH);
  localparam logic [LW-1:0] READY_LIMIT  = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [31:0]   THRESH_WORDS = 32'((THRESHOLD_BYTES * 8 + DATA_WIDTH - 1) / DATA_WIDTH);

  frame_state_e  state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] lines_q, lines_d;
  logic          ready_q, ready_d;
  logic          not_empty_q, not_empty_d;
  logic          line_ready_q, line_ready_d;
  logic          framing_err_q, framing_err_d;
  logic          underflow_err_q, underflow_err_d;

  logic          handshake;
  logic          accept;
  logic          frame_violation;
  logic          wr_en;
  logic          rd_en;
  logic [RW-1:0] ram_wr_data;
  logic [RW-1:0] ram_rd_data;

  // Ready is masked during flush so a source never believes a discarded word was taken.
  assign avl_st_in_ready = ready_q & ~flush;
  assign handshake       = avl_st_in_ready & avl_st_in_valid;

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    frame_violation = 1'b0;
    if (handshake) begin
      case (state_q)
        ST_IDLE: begin
          if (avl_st_in_startofpacket) begin
            accept  = 1'b1;
            state_d = avl_st_in_endofpacket ? ST_IDLE : ST_IN_LINE;
          end else begin
            frame_violation = 1'b1;
          end
        end
        ST_IN_LINE: begin
          accept          = 1'b1;
          frame_violation = avl_st_in_startofpacket;
          state_d         = avl_st_in_endofpacket ? ST_IDLE : ST_IN_LINE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  assign wr_en       = accept & ~flush;
  assign rd_en       = fifo_read_ack & not_empty_q & ~flush;
  assign ram_wr_data = {avl_st_in_startofpacket, avl_st_in_endofpacket, avl_st_in_data};

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    lines_d         = lines_q;
    framing_err_d   = framing_err_q | frame_violation;
    underflow_err_d = underflow_err_q | (fifo_read_ack & ~not_empty_q);
    line_ready_d    = (lines_q != '0) | (32'(level_q) >= THRESH_WORDS);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      lines_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      case ({wr_en & avl_st_in_endofpacket, rd_en & ram_rd_data[SB_EOP]})
        2'b10:   lines_d = lines_q + LW'(1);
        2'b01:   lines_d = lines_q - LW'(1);
        default: lines_d = lines_q;
      endcase
    end

    // The RAM reads the next head address each edge; a word landing in that slot
    // on the same edge is only visible one edge later.
    not_empty_d = (level_d != '0) & ~(wr_en & (level_d == LW'(1)));
    ready_d     = ~flush & (level_d < READY_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      lines_q         <= '0;
      ready_q         <= 1'b0;
      not_empty_q     <= 1'b0;
      line_ready_q    <= 1'b0;
      framing_err_q   <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      lines_q         <= lines_d;
      ready_q         <= ready_d;
      not_empty_q     <= not_empty_d;
      line_ready_q    <= line_ready_d;
      framing_err_q   <= framing_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  dsi_sc_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (ram_wr_data),
    .rd_en   (1'b1),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  assign fifo_data       = not_empty_q ? ram_rd_data[DATA_WIDTH-1:0] : '0;
  assign fifo_sop        = not_empty_q & ram_rd_data[SB_SOP];
  assign fifo_eop        = not_empty_q & ram_rd_data[SB_EOP];
  assign fifo_not_empty  = not_empty_q;
  assign fifo_line_ready = line_ready_q;
  assign fifo_level      = level_q;
  assign lines_held      = lines_q;
  assign framing_err     = framing_err_q;
  assign underflow_err   = underflow_err_q;

`ifdef DSI_TX_LINE_BUFFER_WATERMARK_EN
  logic [LW-1:0] max_level_q, max_level_d;

  always_comb begin
    max_level_d = max_level_q;
    if (flush) begin
      max_level_d = '0;
    end else if (level_q > max_level_q) begin
      max_level_d = level_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end

  assign max_level = max_level_q;
`endif

endmodule
